// File: rtl/cordic_batch_sched.sv
// Streams a batch of NPTS points through a pipelined CORDIC core and writes results back by index.
// Optional ANGLE_QUAD_FOLD_EN: fold |theta| > pi/2 into range and negate the results.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start; core out of reset
// S_CLR   | two cycles holding the core in reset to flush stale data
// S_ISSUE | one point per cycle read from the store and sent to the core
// S_DRAIN | waiting LAT cycles for the last result to emerge
// S_DONE  | one-cycle done pulse
module cordic_batch_sched #(
    parameter int NPTS = 18,
    parameter int LAT  = 6,
    parameter int IW   = 12,
    parameter int AW   = 13,
    parameter int OW   = 10
) (
    input  logic          CLOCK_50,
    input  logic          resetn,
    input  logic          start,
    input  logic [AW-1:0] theta,
    output logic          busy,
    output logic          done,
    output logic [4:0]    pt_addr,
    input  logic [IW-1:0] pt_x,
    input  logic [IW-1:0] pt_y,
    output logic          cordic_areset,
    output logic [AW-1:0] cordic_a,
    output logic [IW-1:0] cordic_x,
    output logic [IW-1:0] cordic_y,
    input  logic [OW-1:0] cordic_xo,
    input  logic [OW-1:0] cordic_yo,
    output logic          res_we,
    output logic [4:0]    res_addr,
    output logic [OW-1:0] res_x,
    output logic [OW-1:0] res_y
);

    localparam int TW = $clog2(LAT + 2);

    typedef enum logic [2:0] {S_IDLE, S_CLR, S_ISSUE, S_DRAIN, S_DONE} state_t;

    state_t state, state_nxt;
    logic [TW-1:0] tmr;
    logic [AW-1:0] a_reg;
    logic [AW-1:0] a_next;
    logic          last_pt;
    logic          accept;
    logic          iss_v;
    logic [4:0]    iss_idx;
    logic [LAT-1:0]      tag_v;
    logic [LAT-1:0][4:0] tag_idx;
    logic          areset_fsm;

    assign accept  = (state == S_IDLE) && start;
    assign last_pt = (pt_addr == 5'(NPTS - 1));

`ifdef ANGLE_QUAD_FOLD_EN
    localparam logic signed [AW-1:0] HALF_PI = AW'(12'h648);
    localparam logic signed [AW-1:0] PI      = AW'(12'hC91);

    logic fold_req;
    logic fold_q;

    function automatic logic [OW-1:0] neg_sat(input logic [OW-1:0] v);
        if (v == {1'b1, {(OW-1){1'b0}}})
            return {1'b0, {(OW-1){1'b1}}};
        return ~v + 1'b1;
    endfunction

    always_comb begin
        fold_req = ($signed(theta) > HALF_PI) || ($signed(theta) < -HALF_PI);
        a_next   = theta;
        if (fold_req)
            a_next = theta[AW-1] ? (theta + PI) : (theta - PI);
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn)
            fold_q <= 1'b0;
        else if (accept)
            fold_q <= fold_req;
    end
`else
    assign a_next = theta;
`endif

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_CLR;
            S_CLR:   if (tmr == '0) state_nxt = S_ISSUE;
            S_ISSUE: if (last_pt) state_nxt = S_DRAIN;
            S_DRAIN: if (tmr == '0) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy       = (state != S_IDLE);
        done       = (state == S_DONE);
        areset_fsm = (state == S_CLR);
    end

    // Core stays in reset while the block itself is held in reset.
    assign cordic_areset = areset_fsm | ~resetn;

    // Shared down-counter: CLR length on start, drain length after the last issue.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            tmr     <= '0;
            pt_addr <= '0;
            a_reg   <= '0;
        end else begin
            if (accept)
                tmr <= TW'(1);
            else if (state == S_ISSUE && last_pt)
                tmr <= TW'(LAT);
            else if (tmr != '0)
                tmr <= tmr - 1'b1;

            if (accept)
                pt_addr <= '0;
            else if (state == S_ISSUE && !last_pt)
                pt_addr <= pt_addr + 5'd1;

            if (accept)
                a_reg <= a_next;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            iss_v   <= 1'b0;
            iss_idx <= '0;
            tag_v   <= '0;
            tag_idx <= '0;
        end else begin
            iss_v      <= (state == S_ISSUE);
            iss_idx    <= pt_addr;
            tag_v[0]   <= iss_v;
            tag_idx[0] <= iss_idx;
            for (int i = 1; i < LAT; i++) begin
                tag_v[i]   <= tag_v[i-1];
                tag_idx[i] <= tag_idx[i-1];
            end
        end
    end

    // Store data arrives one cycle after the address, aligned with iss_v.
    assign cordic_a = a_reg;
    assign cordic_x = iss_v ? pt_x : '0;
    assign cordic_y = iss_v ? pt_y : '0;

    always_comb begin
        res_we   = tag_v[LAT-1];
        res_addr = res_we ? tag_idx[LAT-1] : '0;
        res_x    = res_we ? cordic_xo : '0;
        res_y    = res_we ? cordic_yo : '0;
`ifdef ANGLE_QUAD_FOLD_EN
        if (res_we && fold_q) begin
            res_x = neg_sat(cordic_xo);
            res_y = neg_sat(cordic_yo);
        end
`endif
    end

endmodule

// File: tb/tb_cordic_batch_sched.sv
// Bench for cordic_batch_sched: behavioural CORDIC core and point store, batch-level
// expectation model checked every cycle, plus directed literal checks.
module tb_cordic_batch_sched;

    localparam int NPTS = 18;
    localparam int LAT  = 6;
    localparam int IW   = 12;
    localparam int AW   = 13;
    localparam int OW   = 10;
    localparam int BLEN = 4 + NPTS + LAT;

    logic          CLOCK_50 = 1'b0;
    logic          resetn   = 1'b0;
    logic          start    = 1'b0;
    logic [AW-1:0] theta    = '0;
    logic          busy, done, cordic_areset, res_we;
    logic [4:0]    pt_addr, res_addr;
    logic [IW-1:0] pt_x = '0, pt_y = '0, cordic_x, cordic_y;
    logic [AW-1:0] cordic_a;
    logic [OW-1:0] cordic_xo, cordic_yo, res_x, res_y;

    cordic_batch_sched #(.NPTS(NPTS), .LAT(LAT), .IW(IW), .AW(AW), .OW(OW)) dut (
        .CLOCK_50(CLOCK_50), .resetn(resetn), .start(start), .theta(theta),
        .busy(busy), .done(done), .pt_addr(pt_addr), .pt_x(pt_x), .pt_y(pt_y),
        .cordic_areset(cordic_areset), .cordic_a(cordic_a), .cordic_x(cordic_x),
        .cordic_y(cordic_y), .cordic_xo(cordic_xo), .cordic_yo(cordic_yo),
        .res_we(res_we), .res_addr(res_addr), .res_x(res_x), .res_y(res_y)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int cyc = 0;
    always @(posedge CLOCK_50) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic chk_tol(input string name, input int got, input int exp, input int tol);
        checks++;
        if (got - exp > tol || exp - got > tol) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d +/-%0d (cycle %0d)", name, got, exp, tol, cyc);
        end
    endtask

    // Rotation of a Q2.10 point by a Q3.10 angle, result scaled to Q2.8.
    function automatic real rot_x(input int px, input int py, input int th);
        real a;
        a = th / 1024.0;
        return (px * $cos(a) - py * $sin(a)) / 4.0;
    endfunction

    function automatic real rot_y(input int px, input int py, input int th);
        real a;
        a = th / 1024.0;
        return (px * $sin(a) + py * $cos(a)) / 4.0;
    endfunction

    function automatic int rnd(input real v);
        int n;
        n = (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
        if (n > 511) n = 511;
        if (n < -512) n = -512;
        return n;
    endfunction

    // Point store: synchronous read, data one cycle after the address.
    int tbl_x[32], tbl_y[32];
    always @(posedge CLOCK_50) begin
        pt_x <= IW'(tbl_x[pt_addr]);
        pt_y <= IW'(tbl_y[pt_addr]);
    end

    // Behavioural core: LAT-cycle pipelined rotation, flushed by areset.
    int cx[LAT], cy[LAT];
    always @(posedge CLOCK_50) begin
        if (cordic_areset) begin
            for (int i = 0; i < LAT; i++) begin
                cx[i] <= 0;
                cy[i] <= 0;
            end
        end else begin
            cx[0] <= rnd(rot_x($signed(cordic_x), $signed(cordic_y), $signed(cordic_a)));
            cy[0] <= rnd(rot_y($signed(cordic_x), $signed(cordic_y), $signed(cordic_a)));
            for (int i = 1; i < LAT; i++) begin
                cx[i] <= cx[i-1];
                cy[i] <= cy[i-1];
            end
        end
    end
    assign cordic_xo = OW'(cx[LAT-1]);
    assign cordic_yo = OW'(cy[LAT-1]);

    // Batch model: start cycle, unfolded angle and snapshot of the points.
    bit b_act = 0;
    int b_c0 = 0;
    int b_th = 0;
    int b_px[32], b_py[32];

    int wr_cnt = 0, done_cnt = 0, done_cyc = 0, first_wr_cyc = 0;
    int last_rx = 0, last_ry = 0, last_addr = 0;

    always @(negedge CLOCK_50) begin
        int k;
        bit e_busy, e_done, e_we, e_ar;
        k = cyc - (b_c0 + 4 + LAT);
        if (!resetn) begin
            e_busy = 0; e_done = 0; e_we = 0; e_ar = 1;
        end else begin
            e_ar   = b_act && cyc >= b_c0 + 1 && cyc <= b_c0 + 2;
            e_busy = b_act && cyc >= b_c0 + 1 && cyc <= b_c0 + BLEN;
            e_done = b_act && cyc == b_c0 + BLEN;
            e_we   = b_act && k >= 0 && k < NPTS;
        end
        chk("busy", busy, e_busy);
        chk("done", done, e_done);
        chk("res_we", res_we, e_we);
        chk("cordic_areset", cordic_areset, e_ar);
        if (e_we && res_we) begin
            chk("res_addr", res_addr, k);
            chk_tol("res_x", $signed(res_x), rnd(rot_x(b_px[k], b_py[k], b_th)), 1);
            chk_tol("res_y", $signed(res_y), rnd(rot_y(b_px[k], b_py[k], b_th)), 1);
        end
        if (res_we) begin
            wr_cnt++;
            last_rx   = $signed(res_x);
            last_ry   = $signed(res_y);
            last_addr = res_addr;
            if (res_addr == 0) first_wr_cyc = cyc;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic fill(input int x, input int y);
        for (int i = 0; i < 32; i++) begin
            tbl_x[i] = x;
            tbl_y[i] = y;
        end
    endtask

    // Called 1 time unit after a rising edge; returns at the same phase one cycle later.
    task automatic pulse(input int th);
        start = 1'b1;
        theta = AW'(th);
        if (resetn && (!b_act || cyc > b_c0 + BLEN)) begin
            b_act = 1;
            b_c0  = cyc;
            b_th  = th;
            for (int i = 0; i < 32; i++) begin
                b_px[i] = tbl_x[i];
                b_py[i] = tbl_y[i];
            end
        end
        @(posedge CLOCK_50);
        #1;
        start = 1'b0;
    endtask

    task automatic go_to(input int c);
        while (cyc < c) begin
            @(posedge CLOCK_50);
            #1;
        end
    endtask

    int c0, c1, w0, d0;

    initial begin
        fill(0, 0);
        repeat (3) @(posedge CLOCK_50);
        #1;
        chk("rst pt_addr", pt_addr, 0);
        chk("rst cordic_x", cordic_x, 0);
        chk("rst cordic_a", cordic_a, 0);
        chk("rst res_x", res_x, 0);
        resetn = 1'b1;
        @(posedge CLOCK_50);
        #1;

        // pi/4 batch on (0.5, 0)
        fill(12'h200, 0);
        w0 = wr_cnt; d0 = done_cnt; c0 = cyc;
        pulse(13'h324);
        go_to(c0 + BLEN + 3);
        chk("b2 writes", wr_cnt - w0, 18);
        chk("b2 dones", done_cnt - d0, 1);
        chk("b2 done cycle", done_cyc - c0, 28);
        chk("b2 first write cycle", first_wr_cyc - c0, 10);
        chk("b2 last addr", last_addr, 17);
        chk_tol("b2 res_x", last_rx, 'h05A, 1);
        chk_tol("b2 res_y", last_ry, 'h05A, 1);

        // start during busy must not re-latch theta
        w0 = wr_cnt; d0 = done_cnt; c0 = cyc;
        pulse(13'h324);
        go_to(c0 + 5);
        pulse(0);
        go_to(c0 + BLEN + 3);
        chk("b3 writes", wr_cnt - w0, 18);
        chk("b3 dones", done_cnt - d0, 1);
        chk_tol("b3 res_x", last_rx, 'h05A, 1);
        chk_tol("b3 res_y", last_ry, 'h05A, 1);

        // start in the DONE cycle is ignored
        w0 = wr_cnt; d0 = done_cnt; c0 = cyc;
        pulse(13'h324);
        go_to(c0 + BLEN);
        pulse(0);
        go_to(c0 + BLEN + 12);
        chk("done-cycle start writes", wr_cnt - w0, 18);
        chk("done-cycle start dones", done_cnt - d0, 1);

        // back-to-back: second start on the first IDLE cycle
        w0 = wr_cnt; d0 = done_cnt; c0 = cyc;
        pulse(13'h324);
        go_to(c0 + BLEN + 1);
        c1 = cyc;
        pulse(13'h324);
        go_to(c1 + BLEN + 3);
        chk("b2b writes", wr_cnt - w0, 36);
        chk("b2b dones", done_cnt - d0, 2);
        chk("b2b second done cycle", done_cyc - c1, 28);

        // identity angle
        fill(12'h100, 12'h0C0);
        c0 = cyc;
        pulse(0);
        go_to(c0 + BLEN + 3);
        chk_tol("id res_x", last_rx, 'h040, 1);
        chk_tol("id res_y", last_ry, 'h030, 1);

        // per-index data checks ordering of store reads
        for (int i = 0; i < 32; i++) begin
            tbl_x[i] = i * 64 - 512;
            tbl_y[i] = 496 - i * 24;
        end
        c0 = cyc;
        pulse(0);
        go_to(c0 + BLEN + 3);
        chk_tol("ramp res_x", last_rx, 144, 1);
        chk_tol("ramp res_y", last_ry, 22, 1);

`ifdef ANGLE_QUAD_FOLD_EN
        fill(12'h200, 0);
        c0 = cyc;
        pulse(13'hC91);
        go_to(c0 + BLEN + 3);
        chk_tol("fold pi res_x", last_rx, -128, 1);
        chk_tol("fold pi res_y", last_ry, 0, 1);

        fill(12'h200, 12'h100);
        c0 = cyc;
        pulse(-2048);
        go_to(c0 + BLEN + 3);

        fill(-2048, 0);
        c0 = cyc;
        pulse(13'hC91);
        go_to(c0 + BLEN + 3);
        chk_tol("fold saturate res_x", last_rx, 511, 1);
`endif

        // reset in the middle of ISSUE aborts the batch
        fill(12'h200, 0);
        w0 = wr_cnt; d0 = done_cnt; c0 = cyc;
        pulse(13'h324);
        go_to(c0 + 10);
        resetn = 1'b0;
        b_act  = 0;
        #1;
        chk("abort busy", busy, 0);
        chk("abort res_we", res_we, 0);
        chk("abort areset", cordic_areset, 1);
        repeat (2) @(posedge CLOCK_50);
        #1;
        resetn = 1'b1;
        go_to(c0 + 45);
        chk("abort writes", wr_cnt - w0, 0);
        chk("abort dones", done_cnt - d0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
